// File: rtl/cond_unit_pkg.sv
// Shared types for the execute-stage condition unit: condition codes,
// NZCV bit positions and the flag record.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Pure combinational decode of the condition field against a set of flags.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx_raw
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic ge_s;

    assign n_s  = Flags[FLAG_N];
    assign z_s  = Flags[FLAG_Z];
    assign c_s  = Flags[FLAG_C];
    assign v_s  = Flags[FLAG_V];
    assign ge_s = (n_s == v_s);

    // Condition-code decode; NV never passes
    always_comb begin
        CondEx_raw = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx_raw = z_s;
            COND_NE: CondEx_raw = ~z_s;
            COND_CS: CondEx_raw = c_s;
            COND_CC: CondEx_raw = ~c_s;
            COND_MI: CondEx_raw = n_s;
            COND_PL: CondEx_raw = ~n_s;
            COND_VS: CondEx_raw = v_s;
            COND_VC: CondEx_raw = ~v_s;
            COND_HI: CondEx_raw = c_s & ~z_s;
            COND_LS: CondEx_raw = ~c_s | z_s;
            COND_GE: CondEx_raw = ge_s;
            COND_LT: CondEx_raw = ~ge_s;
            COND_GT: CondEx_raw = ~z_s & ge_s;
            COND_LE: CondEx_raw = z_s | ~ge_s;
            COND_AL: CondEx_raw = 1'b1;
            COND_NV: CondEx_raw = 1'b0;
            default: CondEx_raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV flag register plus condition-gated
// PC/register/memory write enables.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ValidE,
    input  logic       StallE,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_r;
    logic       cond_raw_s;
    logic       flag_en_s;

    // Evaluated against the registered flags so a same-cycle write is not seen
    cond_check u_cond_check (
        .Cond       (Cond),
        .Flags      (flags_r),
        .CondEx_raw (cond_raw_s)
    );

    assign CondEx    = ValidE & cond_raw_s;
    assign PCSrc     = PCS  & CondEx;
    assign RegWrite  = RegW & CondEx;
    assign MemWrite  = MemW & CondEx;
    assign Flags     = flags_r;
    assign flag_en_s = CondEx & ~StallE;

    // Flag register; N/Z and C/V halves are written independently
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= FLAG_RST;
        end else if (flag_en_s) begin
            if (FlagW[1]) begin
                flags_r[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_r[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidE;
    logic       StallE;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int checks = 0;
    int errors = 0;

    cond_unit #(.FLAG_RST(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .ValidE   (ValidE),
        .StallE   (StallE),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af);
        Cond = c; FlagW = fw; ALUFlags = af;
        #1;
    endtask

    initial begin
        reset = 1'b1; ValidE = 1'b1; StallE = 1'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        drive(4'b1110, 2'b11, 4'b1111);
        tick();
        chk("reset_flags", Flags, 4'b0000);
        reset = 1'b0;

        drive(4'b0000, 2'b00, 4'b0000);
        chk("rst_eq", {3'b000, CondEx}, 4'b0000);
        drive(4'b0001, 2'b00, 4'b0000);
        chk("rst_ne", {3'b000, CondEx}, 4'b0001);
        drive(4'b1110, 2'b00, 4'b0000);
        chk("rst_al", {3'b000, CondEx}, 4'b0001);

        // ADDS then EQ-conditioned register write
        drive(4'b1110, 2'b11, 4'b0100);
        tick();
        chk("adds_flags", Flags, 4'b0100);
        RegW = 1'b1;
        drive(4'b0000, 2'b00, 4'b0000);
        chk("eq_condex", {3'b000, CondEx}, 4'b0001);
        chk("eq_regwrite", {3'b000, RegWrite}, 4'b0001);
        RegW = 1'b0;

        // Partial N/Z write
        drive(4'b1110, 2'b11, 4'b1010);
        tick();
        chk("set_1010", Flags, 4'b1010);
        drive(4'b1110, 2'b10, 4'b0101);
        tick();
        chk("partial_nz", Flags, 4'b0110);

        // Partial C/V write
        drive(4'b1110, 2'b11, 4'b0000);
        tick();
        drive(4'b1110, 2'b01, 4'b1111);
        tick();
        chk("partial_cv", Flags, 4'b0011);
        drive(4'b0010, 2'b00, 4'b0000);
        chk("cs_pass", {3'b000, CondEx}, 4'b0001);
        drive(4'b0011, 2'b00, 4'b0000);
        chk("cc_fail", {3'b000, CondEx}, 4'b0000);
        drive(4'b0110, 2'b00, 4'b0000);
        chk("vs_pass", {3'b000, CondEx}, 4'b0001);

        // Failed condition blocks writes and flag update
        drive(4'b1110, 2'b11, 4'b0000);
        tick();
        MemW = 1'b1; PCS = 1'b1;
        drive(4'b0000, 2'b11, 4'b1111);
        chk("fail_condex", {3'b000, CondEx}, 4'b0000);
        chk("fail_memwrite", {3'b000, MemWrite}, 4'b0000);
        chk("fail_pcsrc", {3'b000, PCSrc}, 4'b0000);
        tick();
        chk("fail_flags", Flags, 4'b0000);

        // Same-cycle write uses pre-write flags
        drive(4'b0001, 2'b11, 4'b0100);
        chk("prewrite_condex", {3'b000, CondEx}, 4'b0001);
        chk("prewrite_pcsrc", {3'b000, PCSrc}, 4'b0001);
        tick();
        chk("prewrite_flags", Flags, 4'b0100);
        chk("postwrite_condex", {3'b000, CondEx}, 4'b0000);
        MemW = 1'b0; PCS = 1'b0;

        // Stall freezes flags but not outputs
        StallE = 1'b1; RegW = 1'b1;
        drive(4'b1110, 2'b11, 4'b1111);
        chk("stall_regwrite", {3'b000, RegWrite}, 4'b0001);
        tick();
        chk("stall_flags", Flags, 4'b0100);
        StallE = 1'b0;

        // Bubble suppresses everything
        ValidE = 1'b0;
        drive(4'b1110, 2'b11, 4'b1111);
        chk("bubble_regwrite", {3'b000, RegWrite}, 4'b0000);
        chk("bubble_condex", {3'b000, CondEx}, 4'b0000);
        tick();
        chk("bubble_flags", Flags, 4'b0100);
        ValidE = 1'b1; RegW = 1'b0;

        // Signed compares with N=1, V=0
        drive(4'b1110, 2'b11, 4'b1000);
        tick();
        chk("set_1000", Flags, 4'b1000);
        drive(4'b1011, 2'b00, 4'b0000);
        chk("lt", {3'b000, CondEx}, 4'b0001);
        drive(4'b1101, 2'b00, 4'b0000);
        chk("le", {3'b000, CondEx}, 4'b0001);
        drive(4'b1010, 2'b00, 4'b0000);
        chk("ge", {3'b000, CondEx}, 4'b0000);
        drive(4'b1100, 2'b00, 4'b0000);
        chk("gt", {3'b000, CondEx}, 4'b0000);
        drive(4'b1111, 2'b00, 4'b0000);
        chk("nv", {3'b000, CondEx}, 4'b0000);
        drive(4'b0100, 2'b00, 4'b0000);
        chk("mi", {3'b000, CondEx}, 4'b0001);
        drive(4'b1000, 2'b00, 4'b0000);
        chk("hi", {3'b000, CondEx}, 4'b0000);
        drive(4'b1001, 2'b00, 4'b0000);
        chk("ls", {3'b000, CondEx}, 4'b0001);

        // Reset mid-operation discards a pending write
        reset = 1'b1;
        drive(4'b1110, 2'b11, 4'b0111);
        tick();
        chk("midreset_flags", Flags, 4'b0000);
        reset = 1'b0;
        drive(4'b0000, 2'b00, 4'b0000);
        chk("midreset_eq", {3'b000, CondEx}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter FLAG_RST, default 4'b0000, is the reset value of the NZCV flag register.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ValidE  input  1  execute-stage instruction valid; 0 = bubble/flushed slot.
REQ-005 StallE  input  1  execute stage stalled; flag register holds.
REQ-006 Cond  input  4  instruction condition field [31:28].
REQ-007 ALUFlags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
REQ-008 FlagW  input  2  flag-write request from the ALU decoder; [1] updates N,Z; [0] updates C,V.
REQ-009 PCS, RegW, MemW  input  1 each  unconditioned PC-write, register-write and memory-write requests.
REQ-010 PCSrc, RegWrite, MemWrite  output  1 each  condition-gated write enables.
REQ-011 CondEx  output  1  condition passed for the current instruction.
REQ-012 Flags  output  4  registered {N,Z,C,V}.

Function
REQ-013 CondEx SHALL be combinational from Cond and the registered Flags, never from ALUFlags.
REQ-014 Cond decode SHALL be as follows:
- EQ=Z; NE=!Z; CS=C; CC=!C; MI=N; PL=!N; VS=V; VC=!V.
- HI=C&!Z; LS=!C|Z; GE=(N==V); LT=(N!=V); GT=!Z&(N==V); LE=Z|(N!=V).
- AL(1110)=1; 1111=0.
REQ-015 CondEx SHALL be forced to 0 when ValidE=0.
REQ-016 PCSrc SHALL equal PCS&CondEx; RegWrite SHALL equal RegW&CondEx; MemWrite SHALL equal MemW&CondEx.
REQ-017 On a rising edge with reset=0, StallE=0 and CondEx=1:
- Flags[3:2] SHALL load ALUFlags[3:2] if FlagW[1]=1.
- Flags[1:0] SHALL load ALUFlags[1:0] if FlagW[0]=1.
REQ-018 Flags SHALL hold when CondEx=0, StallE=1, or FlagW bit=0; each half is enabled independently.
REQ-019 Flag update latency SHALL be one cycle: an instruction in execute at cycle t+1 evaluates its Cond against flags written at cycle t.
REQ-020 StallE=1 SHALL NOT suppress the combinational outputs; only the flag register is frozen.
REQ-021 Simultaneous FlagW write and a condition evaluation in the same cycle SHALL use pre-write flags.

Reset
REQ-022 While reset=1 at a rising edge, Flags SHALL load FLAG_RST, overriding StallE and FlagW.
REQ-023 Because outputs are combinational from Flags, after reset with Flags=0000:
- CondEx=0 for EQ.
- CondEx=1 for NE and AL.
REQ-024 Reset asserted mid-operation SHALL discard any pending flag write in that cycle.

Structure
REQ-025 A shared package SHALL hold:
- the 4-bit condition-code enum (EQ..AL, NV=4'b1111);
- flag bit index constants N=3, Z=2, C=1, V=0;
- the flag-record typedef.
REQ-026 Condition evaluation SHALL be a combinational sub-module cond_check (Cond, Flags -> CondEx_raw).
REQ-027 cond_unit SHALL contain the flag register, the valid/stall gating and the output gating.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset: reset=1 one edge with FlagW=11 and ALUFlags=1111 -> Flags=0000.
- Two instructions: ADDS (Cond=1110, FlagW=11, ALUFlags=0100), then Cond=0000, RegW=1 -> Flags=0100, next-cycle CondEx=1, RegWrite=1.
- Partial write: with Flags=1010, FlagW=10, ALUFlags=0101 -> Flags=0110 after the edge.
- Failed condition: Flags=0000, Cond=0000, FlagW=11, MemW=1, PCS=1 -> CondEx=0, MemWrite=0, PCSrc=0, Flags unchanged.
- Stall and bubble: StallE=1 with FlagW=11, ALUFlags=1111 -> Flags held; ValidE=0 with Cond=1110, RegW=1 -> RegWrite=0.
- Signed compare: Flags N=1,V=0 -> LT and LE give CondEx=1; GE and GT give 0; Cond=1111 gives 0.
